// File: rtl/shift_result_wb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : shift_result_wb_pkg
// Brief    : Shared constants and record layout for the shift-result
//            writeback receiver.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
package shift_result_wb_pkg;

  localparam int c_REG_WIDTH  = 9;
  localparam int c_VAL_WIDTH  = 64;
  localparam int c_FLAG_WIDTH = 6;

  // COASZP flag bit positions inside the flag field (C is the MSB)
  localparam int c_FLAG_C = 5;
  localparam int c_FLAG_O = 4;
  localparam int c_FLAG_A = 3;
  localparam int c_FLAG_S = 2;
  localparam int c_FLAG_Z = 1;
  localparam int c_FLAG_P = 0;

  // One joined shift result as it travels to writeback
  typedef struct packed {
    logic                    thread;
    logic [c_REG_WIDTH-1:0]  dst_reg;
    logic [c_VAL_WIDTH-1:0]  val;
    logic [c_FLAG_WIDTH-1:0] flags;
  } shift_rec_t;

endpackage
`default_nettype wire

// File: rtl/shift_wb_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : shift_wb_fifo
// Brief    : Circular record queue with per-slot live bits, per-thread flush
//            and automatic skipping of flushed (hole) slots at the head.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module shift_wb_fifo #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 79
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    push_thread,
  input  logic [DATA_WIDTH-1:0]   push_data,
  input  logic                    flush,
  input  logic                    flush_thread,
  input  logic                    ready,
  output logic                    valid,
  output logic                    out_thread,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  logic [DEPTH-1:0]       r_v;
  logic [DEPTH-1:0]       r_thread;
  logic [DATA_WIDTH-1:0]  r_data [DEPTH];
  logic [c_PTR_W-1:0]     r_head;
  logic [c_PTR_W-1:0]     r_tail;
  logic [c_CNT_W-1:0]     r_count;

  logic w_occupied;
  logic w_head_kill;
  logic w_valid;
  logic w_pop;
  logic w_skip;
  logic w_adv;
  logic w_full;
  logic w_push;

  assign w_occupied  = (r_count != '0);
  // A flush aimed at the head's thread hides it in the same cycle
  assign w_head_kill = flush & (r_thread[r_head] == flush_thread);
  assign w_valid     = w_occupied & r_v[r_head] & ~w_head_kill;
  assign w_pop       = w_valid & ready;
  assign w_skip      = w_occupied & ~r_v[r_head];
  assign w_adv       = w_pop | w_skip;
  assign w_full      = (r_count == c_CNT_W'(DEPTH));
  assign w_push      = push & ~w_full;

  // Pointer, occupancy and live-bit bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_v      <= '0;
      r_thread <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (flush && (r_thread[i] == flush_thread)) begin
          r_v[i] <= 1'b0;
        end
      end
      if (w_adv) begin
        r_v[r_head] <= 1'b0;
        r_head      <= r_head + 1'b1;
      end
      // head and tail only coincide when empty or full, so this never
      // collides with the head clear above
      if (w_push) begin
        r_v[r_tail]      <= ~(flush & (push_thread == flush_thread));
        r_thread[r_tail] <= push_thread;
        r_tail           <= r_tail + 1'b1;
      end
      case ({w_push, w_adv})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage; validity lives in r_v so no reset is needed here
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_data[r_tail] <= push_data;
    end
  end

  assign valid      = w_valid;
  assign out_thread = w_valid ? r_thread[r_head] : 1'b0;
  assign out_data   = w_valid ? r_data[r_head] : '0;
  assign count      = r_count;

endmodule
`default_nettype wire

// File: rtl/shift_result_wb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : shift_result_wb
// Brief    : Joins each shift result value with its one-cycle-late COASZP
//            flags, queues the records and presents them to writeback over
//            valid/ready, discarding records of a flushed thread.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module shift_result_wb
  import shift_result_wb_pkg::*;
#(
  parameter int REG_WIDTH  = c_REG_WIDTH,
  parameter int DEPTH      = 4,
  parameter int FLAG_WIDTH = c_FLAG_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   except,
  input  logic                   except_thread,
  input  logic                   in_en,
  input  logic                   in_thread,
  input  logic [REG_WIDTH-1:0]   in_reg,
  input  logic [c_VAL_WIDTH-1:0] in_val,
  input  logic [FLAG_WIDTH-1:0]  in_flags,
  output logic                   in_busy,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic                   wb_thread,
  output logic [REG_WIDTH-1:0]   wb_reg,
  output logic [c_VAL_WIDTH-1:0] wb_val,
  output logic [FLAG_WIDTH-1:0]  wb_flags,
  output logic                   ovf
);

  localparam int c_DW    = REG_WIDTH + c_VAL_WIDTH + FLAG_WIDTH;
  localparam int c_CNT_W = $clog2(DEPTH) + 1;

  // Stage register holding the value half of a result until its flags land
  logic                   r_s_v;
  logic                   r_s_thread;
  logic [REG_WIDTH-1:0]   r_s_reg;
  logic [c_VAL_WIDTH-1:0] r_s_val;
  logic                   r_ovf;

  logic                   w_in_kill;
  logic                   w_s_kill;
  logic                   w_push_req;
  logic                   w_full;
  logic [c_DW-1:0]        w_push_data;
  logic [c_DW-1:0]        w_out_data;
  logic [c_CNT_W-1:0]     w_count;
  logic [c_CNT_W:0]       w_occ;

  assign w_in_kill   = except & (in_thread == except_thread);
  assign w_s_kill    = except & (r_s_thread == except_thread);
  // A staged record whose thread is flushed this cycle is simply not pushed
  assign w_push_req  = r_s_v & ~w_s_kill;
  assign w_full      = (w_count == c_CNT_W'(DEPTH));
  assign w_push_data = {r_s_reg, r_s_val, in_flags};

  // Capture the value half of a result; the stage empties unless refilled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s_v      <= 1'b0;
      r_s_thread <= 1'b0;
      r_s_reg    <= '0;
      r_s_val    <= '0;
    end else if (in_en && !w_in_kill) begin
      r_s_v      <= 1'b1;
      r_s_thread <= in_thread;
      r_s_reg    <= in_reg;
      r_s_val    <= in_val;
    end else begin
      r_s_v      <= 1'b0;
    end
  end

  // Sticky record-loss indicator: a joined record met a full queue
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf <= 1'b0;
    end else if (w_push_req && w_full) begin
      r_ovf <= 1'b1;
    end
  end

  shift_wb_fifo #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (c_DW)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push         (w_push_req),
    .push_thread  (r_s_thread),
    .push_data    (w_push_data),
    .flush        (except),
    .flush_thread (except_thread),
    .ready        (wb_ready),
    .valid        (wb_valid),
    .out_thread   (wb_thread),
    .out_data     (w_out_data),
    .count        (w_count)
  );

  // Busy counts the staged record too, leaving room for one in-flight result
  assign w_occ    = {1'b0, w_count} + (c_CNT_W + 1)'(r_s_v);
  assign in_busy  = (w_occ >= (c_CNT_W + 1)'(DEPTH - 1));

  assign wb_reg   = w_out_data[c_DW-1 -: REG_WIDTH];
  assign wb_val   = w_out_data[FLAG_WIDTH +: c_VAL_WIDTH];
  assign wb_flags = w_out_data[FLAG_WIDTH-1:0];
  assign ovf      = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_shift_result_wb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_shift_result_wb
// Brief    : Directed self-checking bench for shift_result_wb.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_shift_result_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        except;
  logic        except_thread;
  logic        in_en;
  logic        in_thread;
  logic [8:0]  in_reg;
  logic [63:0] in_val;
  logic [5:0]  in_flags;
  logic        in_busy;
  logic        wb_valid;
  logic        wb_ready;
  logic        wb_thread;
  logic [8:0]  wb_reg;
  logic [63:0] wb_val;
  logic [5:0]  wb_flags;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  shift_result_wb #(
    .REG_WIDTH  (9),
    .DEPTH      (4),
    .FLAG_WIDTH (6)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .except        (except),
    .except_thread (except_thread),
    .in_en         (in_en),
    .in_thread     (in_thread),
    .in_reg        (in_reg),
    .in_val        (in_val),
    .in_flags      (in_flags),
    .in_busy       (in_busy),
    .wb_valid      (wb_valid),
    .wb_ready      (wb_ready),
    .wb_thread     (wb_thread),
    .wb_reg        (wb_reg),
    .wb_val        (wb_val),
    .wb_flags      (wb_flags),
    .ovf           (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int sent;
    int rcv;
    int last_cap;
    int next_cap;

    rst = 1'b0; except = 1'b0; except_thread = 1'b0;
    in_en = 1'b0; in_thread = 1'b0; in_reg = '0; in_val = '0; in_flags = '0;
    wb_ready = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_valid", wb_valid, 0);
    chk("rst_busy", in_busy, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_val", wb_val, 0);
    rst = 1'b1;
    tick();

    // Single result: value at N, flags at N+1, visible at N+2 only
    in_en = 1'b1; in_thread = 1'b0; in_reg = 9'd5; in_val = 64'h8000_0000_0000_0001;
    chk("single_n", wb_valid, 0);
    tick();
    in_en = 1'b0; in_flags = 6'b100100; wb_ready = 1'b1;
    chk("single_n1", wb_valid, 0);
    tick();
    in_flags = '0;
    chk("single_valid", wb_valid, 1);
    chk("single_thread", wb_thread, 0);
    chk("single_reg", wb_reg, 5);
    chk("single_val", wb_val, 64'h8000_0000_0000_0001);
    chk("single_flags", wb_flags, 6'b100100);
    tick();
    chk("single_after", wb_valid, 0);

    // Back-pressure: four records fill the queue, a fifth is dropped
    wb_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_en = 1'b1; in_thread = 1'b0;
      in_reg = 9'(10 + k); in_val = 64'h1000 + 64'(k); in_flags = 6'(k);
      if (k == 2) chk("bp_busy_lo", in_busy, 0);
      if (k == 3) chk("bp_busy_hi", in_busy, 1);
      tick();
    end
    in_en = 1'b0; in_flags = 6'd5;
    tick();
    in_flags = '0;
    chk("bp_ovf", ovf, 1);
    chk("bp_busy_full", in_busy, 1);
    wb_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk("bp_valid", wb_valid, 1);
      chk("bp_reg", wb_reg, 64'(10 + j));
      chk("bp_val", wb_val, 64'h1000 + 64'(j));
      chk("bp_flags", wb_flags, 64'(j + 1));
      tick();
    end
    chk("bp_drained", wb_valid, 0);
    chk("bp_ovf_sticky", ovf, 1);

    // Asynchronous reset clears the sticky overflow without a clock edge
    #2 rst = 1'b0;
    #1 chk("ovf_cleared", ovf, 0);
    #1 rst = 1'b1;
    tick();

    // Flush: threads 0,1,0,1 queued, thread 1 flushed, holes skipped
    wb_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_en = 1'b1; in_thread = 1'(k);
      in_reg = 9'(20 + k); in_val = 64'h2000 + 64'(k); in_flags = 6'(k);
      tick();
    end
    in_en = 1'b0; in_flags = 6'd4;
    tick();
    in_flags = '0;
    except = 1'b1; except_thread = 1'b1;
    chk("fl_head_valid", wb_valid, 1);
    chk("fl_head_reg", wb_reg, 20);
    tick();
    except = 1'b0; wb_ready = 1'b1;
    chk("fl_rec0", wb_reg, 20);
    chk("fl_rec0_v", wb_valid, 1);
    tick();
    chk("fl_hole1", wb_valid, 0);
    tick();
    chk("fl_rec2_v", wb_valid, 1);
    chk("fl_rec2", wb_reg, 22);
    chk("fl_rec2_flags", wb_flags, 3);
    tick();
    chk("fl_hole3", wb_valid, 0);
    tick();
    chk("fl_empty", wb_valid, 0);
    chk("fl_busy", in_busy, 0);

    // Flush inside the join window, and a capture killed in the same cycle
    in_en = 1'b1; in_thread = 1'b0; in_reg = 9'd30; in_val = 64'h3000;
    tick();
    in_en = 1'b0; except = 1'b1; except_thread = 1'b0; in_flags = 6'd7;
    tick();
    except = 1'b0; in_flags = '0;
    chk("jw_n2", wb_valid, 0);
    tick();
    chk("jw_n3", wb_valid, 0);
    chk("jw_busy", in_busy, 0);
    in_en = 1'b1; in_thread = 1'b1; except = 1'b1; except_thread = 1'b1;
    tick();
    in_en = 1'b0; except = 1'b0;
    tick();
    chk("kill_cap_n2", wb_valid, 0);
    tick();
    chk("kill_cap_n3", wb_valid, 0);

    // Wrap: ten records honouring in_busy, wb_ready toggling
    sent = 0; rcv = 0; last_cap = -1;
    for (int cyc = 0; cyc < 200 && rcv < 10; cyc++) begin
      wb_ready = (cyc % 2 == 0);
      in_flags = (last_cap >= 0) ? 6'(last_cap + 1) : 6'd0;
      if (sent < 10 && !in_busy) begin
        in_en = 1'b1; in_thread = 1'b0;
        in_reg = 9'(40 + sent); in_val = 64'h4000 + 64'(sent);
        next_cap = sent;
        sent++;
      end else begin
        in_en = 1'b0;
        next_cap = -1;
      end
      #1;
      if (wb_valid && wb_ready) begin
        chk("wrap_val", wb_val, 64'h4000 + 64'(rcv));
        chk("wrap_flags", wb_flags, 64'(rcv + 1));
        rcv++;
      end
      tick();
      last_cap = next_cap;
    end
    in_en = 1'b0; in_flags = '0;
    chk("wrap_count", 64'(rcv), 10);
    chk("wrap_no_ovf", ovf, 0);

    // Async reset with three records queued
    wb_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_en = 1'b1; in_thread = 1'b0;
      in_reg = 9'(50 + k); in_val = 64'h5000 + 64'(k); in_flags = 6'(k);
      tick();
    end
    in_en = 1'b0; in_flags = 6'd3;
    tick();
    in_flags = '0;
    tick();
    chk("ar_pre_valid", wb_valid, 1);
    chk("ar_pre_val", wb_val, 64'h5000);
    #2 rst = 1'b0;
    #1;
    chk("ar_valid", wb_valid, 0);
    chk("ar_val", wb_val, 0);
    chk("ar_reg", wb_reg, 0);
    chk("ar_flags", wb_flags, 0);
    chk("ar_busy", in_busy, 0);
    #1 rst = 1'b1;
    wb_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("ar_quiet", wb_valid, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
